// File: rtl/frame_renderer.sv
// frame_renderer: once per frame tick, erases the previous dino/obstacle
// rectangles and redraws ground, dino and obstacle on a 160x120 pixel
// adapter, one registered pixel write per cycle.
// Optional feature macro: RENDER_CLEAR_SCREEN_EN (first frame after reset
// clears the whole screen instead of skipping the erase passes).
module frame_renderer #(
  parameter int          CLOCK_FREQUENCY = 25000000,
  parameter int          FRAME_RATE      = 60,
  parameter int          GROUND_Y        = 100,
  parameter int          DINO_X          = 20,
  parameter int          DINO_W          = 8,
  parameter int          DINO_H          = 10,
  parameter int          OBS_W           = 6,
  parameter int          OBS_H           = 8,
  parameter logic [2:0]  BG_COLOUR       = 3'b000,
  parameter logic [2:0]  DINO_COLOUR     = 3'b111,
  parameter logic [2:0]  OBS_COLOUR      = 3'b100,
  parameter logic [2:0]  GROUND_COLOUR   = 3'b010
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        render_en,
  input  logic [15:0] height,
  input  logic [7:0]  obs_x,
  input  logic        obs_valid,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        writeEn,
  output logic        busy,
  output logic        frame_done
);

  localparam int         FRAME_DIV    = CLOCK_FREQUENCY / FRAME_RATE;
  localparam int         SCREEN_W     = 160;
  localparam int         SCREEN_H     = 120;
  localparam int         DINO_TOP_MAX = GROUND_Y - DINO_H;
  localparam logic [6:0] OBS_TOP      = 7'(GROUND_Y - OBS_H);

  typedef enum logic [3:0] {
    IDLE,
    LATCH,
    ERASE_DINO,
    ERASE_OBS,
    DRAW_GND,
    DRAW_DINO,
    DRAW_OBS,
    DONE
`ifdef RENDER_CLEAR_SCREEN_EN
    , CLEAR_ALL
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  px_q, px_d;
  logic [6:0]  py_q, py_d;
  logic        first_q, first_d;
  logic [6:0]  cur_top_q, cur_top_d;
  logic [7:0]  cur_ox_q, cur_ox_d;
  logic        cur_ov_q, cur_ov_d;
  logic [6:0]  prev_top_q, prev_top_d;
  logic [7:0]  prev_ox_q, prev_ox_d;
  logic        prev_ov_q, prev_ov_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        write_en_q, write_en_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;

  // Rectangle currently being scanned and the state that follows it
  logic       in_rect;
  logic [7:0] rect_x;
  logic [6:0] rect_y;
  logic [7:0] rect_w;
  logic [6:0] rect_h;
  logic [2:0] rect_col;
  state_t     rect_next;

  logic       tick;
  logic [6:0] hc;
  logic [8:0] col;
  logic [6:0] row;

  // Clamp requested height so the dino never leaves the top of the screen
  always_comb begin
    if (height > 16'(DINO_TOP_MAX)) hc = 7'(DINO_TOP_MAX);
    else                            hc = height[6:0];
  end

  // Per-state rectangle geometry; skipped passes are folded into rect_next
  always_comb begin
    in_rect   = 1'b0;
    rect_x    = '0;
    rect_y    = '0;
    rect_w    = 8'd1;
    rect_h    = 7'd1;
    rect_col  = BG_COLOUR;
    rect_next = DONE;
    case (state_q)
      ERASE_DINO: begin
        in_rect   = 1'b1;
        rect_x    = 8'(DINO_X);
        rect_y    = prev_top_q;
        rect_w    = 8'(DINO_W);
        rect_h    = 7'(DINO_H);
        rect_col  = BG_COLOUR;
        rect_next = prev_ov_q ? ERASE_OBS : DRAW_GND;
      end
      ERASE_OBS: begin
        in_rect   = 1'b1;
        rect_x    = prev_ox_q;
        rect_y    = OBS_TOP;
        rect_w    = 8'(OBS_W);
        rect_h    = 7'(OBS_H);
        rect_col  = BG_COLOUR;
        rect_next = DRAW_GND;
      end
      DRAW_GND: begin
        in_rect   = 1'b1;
        rect_x    = '0;
        rect_y    = 7'(GROUND_Y);
        rect_w    = 8'(SCREEN_W);
        rect_h    = 7'd1;
        rect_col  = GROUND_COLOUR;
        rect_next = DRAW_DINO;
      end
      DRAW_DINO: begin
        in_rect   = 1'b1;
        rect_x    = 8'(DINO_X);
        rect_y    = cur_top_q;
        rect_w    = 8'(DINO_W);
        rect_h    = 7'(DINO_H);
        rect_col  = DINO_COLOUR;
        rect_next = cur_ov_q ? DRAW_OBS : DONE;
      end
      DRAW_OBS: begin
        in_rect   = 1'b1;
        rect_x    = cur_ox_q;
        rect_y    = OBS_TOP;
        rect_w    = 8'(OBS_W);
        rect_h    = 7'(OBS_H);
        rect_col  = OBS_COLOUR;
        rect_next = DONE;
      end
`ifdef RENDER_CLEAR_SCREEN_EN
      CLEAR_ALL: begin
        in_rect   = 1'b1;
        rect_x    = '0;
        rect_y    = '0;
        rect_w    = 8'(SCREEN_W);
        rect_h    = 7'(SCREEN_H);
        rect_col  = BG_COLOUR;
        rect_next = DRAW_GND;
      end
`endif
      default: ;
    endcase
  end

  // Frame tick counter, FSM sequencing and pixel generation
  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    py_d         = py_q;
    first_d      = first_q;
    cur_top_d    = cur_top_q;
    cur_ox_d     = cur_ox_q;
    cur_ov_d     = cur_ov_q;
    prev_top_d   = prev_top_q;
    prev_ox_d    = prev_ox_q;
    prev_ov_d    = prev_ov_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    write_en_d   = 1'b0;

    tick  = (cnt_q == 32'(FRAME_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 32'd1;

    // 9-bit column so an obstacle near the right edge clips instead of wrapping
    col = {1'b0, rect_x} + {1'b0, px_q};
    row = rect_y + py_q;

    case (state_q)
      IDLE: begin
        if (tick && render_en) state_d = LATCH;
      end
      LATCH: begin
        cur_top_d = 7'(DINO_TOP_MAX) - hc;
        cur_ox_d  = obs_x;
        cur_ov_d  = obs_valid;
        px_d      = '0;
        py_d      = '0;
        if (first_q) begin
`ifdef RENDER_CLEAR_SCREEN_EN
          state_d = CLEAR_ALL;
`else
          state_d = DRAW_GND;
`endif
        end else begin
          state_d = ERASE_DINO;
        end
      end
      DONE: begin
        prev_top_d = cur_top_q;
        prev_ox_d  = cur_ox_q;
        prev_ov_d  = cur_ov_q;
        first_d    = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        if (in_rect) begin
          if (col <= 9'(SCREEN_W - 1)) begin
            write_en_d = 1'b1;
            x_d        = col[7:0];
            y_d        = row;
            colour_d   = rect_col;
          end
          if (px_q == rect_w - 8'd1) begin
            px_d = '0;
            if (py_q == rect_h - 7'd1) begin
              py_d    = '0;
              state_d = rect_next;
            end else begin
              py_d = py_q + 7'd1;
            end
          end else begin
            px_d = px_q + 8'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      px_q         <= '0;
      py_q         <= '0;
      first_q      <= 1'b1;
      cur_top_q    <= '0;
      cur_ox_q     <= '0;
      cur_ov_q     <= 1'b0;
      prev_top_q   <= '0;
      prev_ox_q    <= '0;
      prev_ov_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      write_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      px_q         <= px_d;
      py_q         <= py_d;
      first_q      <= first_d;
      cur_top_q    <= cur_top_d;
      cur_ox_q     <= cur_ox_d;
      cur_ov_q     <= cur_ov_d;
      prev_top_q   <= prev_top_d;
      prev_ox_q    <= prev_ox_d;
      prev_ov_q    <= prev_ov_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      write_en_q   <= write_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign writeEn    = write_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Self-checking bench for frame_renderer (default build, feature macro off).
// Expected pixel writes are pushed to a queue when a frame's inputs are set
// and popped as the DUT raises writeEn.
module tb_frame_renderer;

  logic        Clock = 1'b0;
  logic        reset, render_en, obs_valid;
  logic [15:0] height;
  logic [7:0]  obs_x;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        writeEn, busy, frame_done;

  // Second instance with a short frame period to exercise ticks during busy
  logic        rst2, en2, ov2;
  logic [15:0] h2;
  logic [7:0]  ox2;
  logic [7:0]  x2;
  logic [6:0]  y2;
  logic [2:0]  c2;
  logic        we2, busy2, done2;

  always #5 Clock = ~Clock;

  frame_renderer #(.CLOCK_FREQUENCY(1000), .FRAME_RATE(1)) dut (
    .Clock(Clock), .reset(reset), .render_en(render_en), .height(height),
    .obs_x(obs_x), .obs_valid(obs_valid), .x(x), .y(y), .colour(colour),
    .writeEn(writeEn), .busy(busy), .frame_done(frame_done)
  );

  frame_renderer #(.CLOCK_FREQUENCY(300), .FRAME_RATE(1)) dut2 (
    .Clock(Clock), .reset(rst2), .render_en(en2), .height(h2),
    .obs_x(ox2), .obs_valid(ov2), .x(x2), .y(y2), .colour(c2),
    .writeEn(we2), .busy(busy2), .frame_done(done2)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [17:0] exp_q[$];
  int          exp_cycles;
  bit          m_first;
  int          m_prev_top, m_prev_ox;
  bit          m_prev_ov;

  task automatic push_rect(input int bx, input int by, input int w, input int h,
                           input logic [2:0] c);
    for (int r = 0; r < h; r++) begin
      for (int cc = 0; cc < w; cc++) begin
        exp_cycles++;
        if (bx + cc <= 159) exp_q.push_back({8'(bx + cc), 7'(by + r), c});
      end
    end
  endtask

  task automatic model_frame(input int h, input int ox, input bit ov);
    int top;
    top = 90 - ((h > 90) ? 90 : h);
    exp_cycles = 0;
    if (!m_first) begin
      push_rect(20, m_prev_top, 8, 10, 3'b000);
      if (m_prev_ov) push_rect(m_prev_ox, 92, 6, 8, 3'b000);
    end
    push_rect(0, 100, 160, 1, 3'b010);
    push_rect(20, top, 8, 10, 3'b111);
    if (ov) push_rect(ox, 92, 6, 8, 3'b100);
    m_first    = 1'b0;
    m_prev_top = top;
    m_prev_ox  = ox;
    m_prev_ov  = ov;
  endtask

  task automatic check_pixel(input string name);
    logic [17:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s_extra_write: got x=%0d y=%0d c=%b, expected no write", name, x, y, colour);
    end else begin
      e = exp_q.pop_front();
      if ({x, y, colour} !== e) begin
        miscompares++;
        $display("FAIL %s_pixel: got x=%0d y=%0d c=%b, expected x=%0d y=%0d c=%b",
                 name, x, y, colour, e[17:10], e[9:3], e[2:0]);
      end
    end
  endtask

  task automatic wait_busy(input string name, output bit ok);
    int n;
    int stray;
    n = 0;
    stray = 0;
    while (!busy && n < 2000) begin
      @(negedge Clock);
      if (writeEn) stray++;
      n++;
    end
    ok = busy;
    vectors++;
    if (!busy || stray != 0) begin
      miscompares++;
      $display("FAIL %s_start: got busy=%b idle_writes=%0d, expected busy=1 idle_writes=0", name, busy, stray);
    end
  endtask

  task automatic run_frame(input int h, input int ox, input bit ov, input string name);
    bit ok;
    int k, busy_seen, dones;
    height    = 16'(h);
    obs_x     = 8'(ox);
    obs_valid = ov;
    model_frame(h, ox, ov);
    wait_busy(name, ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    busy_seen = 0;
    dones = 0;
    k = 0;
    while (k < 1000) begin
      if (busy) busy_seen++;
      if (writeEn) check_pixel(name);
      if (k == 3) begin
        // inputs changing mid-frame must not affect this frame
        height    = 16'($urandom);
        obs_x     = 8'($urandom);
        obs_valid = 1'($urandom);
      end
      if (frame_done) begin
        dones++;
        break;
      end
      @(negedge Clock);
      k++;
    end
    @(negedge Clock);
    vectors++;
    if (dones != 1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done: got done=%0d busy_after=%b done_after=%b, expected 1 0 0",
               name, dones, busy, frame_done);
    end
    vectors++;
    if (busy_seen != exp_cycles + 2) begin
      miscompares++;
      $display("FAIL %s_cycles: got busy cycles=%0d, expected %0d", name, busy_seen, exp_cycles + 2);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing: got %0d writes outstanding, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1; rst2 = 1'b1;
    render_en = 1'b1; height = '0; obs_x = '0; obs_valid = 1'b0;
    en2 = 1'b1; h2 = '0; ox2 = 8'd50; ov2 = 1'b1;
    repeat (3) @(negedge Clock);
    vectors++;
    if ({x, y, colour, writeEn, busy, frame_done} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_state: got x=%0d y=%0d c=%b we=%b busy=%b done=%b, expected all 0",
               x, y, colour, writeEn, busy, frame_done);
    end
    vectors++;
    if ({we2, busy2, done2} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_state2: got we=%b busy=%b done=%b, expected 000", we2, busy2, done2);
    end
    reset = 1'b0;
    m_first = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    bit hit;
    int n;
    height = 16'd10; obs_x = 8'd40; obs_valid = 1'b1;
    model_frame(10, 40, 1'b1);
    wait_busy("midreset", ok);
    hit = 1'b0;
    n = 0;
    while (ok && n < 1000) begin
      if (writeEn) begin
        check_pixel("midreset");
        if (y == 7'd100) begin
          hit = 1'b1;
          break;
        end
      end
      @(negedge Clock);
      n++;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL midreset_gnd: got no ground write, expected one");
    end
    reset = 1'b1;
    @(negedge Clock);
    vectors++;
    if (writeEn !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle: got we=%b busy=%b, expected 0 0", writeEn, busy);
    end
    reset = 1'b0;
    exp_q.delete();
    m_first = 1'b1;
    run_frame(5, 70, 1'b1, "post_reset");
  endtask

  task automatic test_render_disabled;
    int wr, dn;
    render_en = 1'b0;
    wr = 0;
    dn = 0;
    repeat (3100) begin
      @(negedge Clock);
      if (writeEn) wr++;
      if (frame_done) dn++;
    end
    vectors++;
    if (wr != 0 || dn != 0) begin
      miscompares++;
      $display("FAIL disabled: got writes=%0d dones=%0d, expected 0 0", wr, dn);
    end
    render_en = 1'b1;
    run_frame(45, 100, 1'b1, "resume");
  endtask

  task automatic test_tick_during_busy;
    int rises[$];
    bit prev;
    int n;
    rst2 = 1'b0;
    prev = 1'b0;
    n = 0;
    while (rises.size() < 3 && n < 2000) begin
      @(negedge Clock);
      if (busy2 && !prev) rises.push_back(n);
      prev = busy2;
      n++;
    end
    vectors++;
    if (rises.size() < 3) begin
      miscompares++;
      $display("FAIL busy_skip_frames: got %0d frame starts, expected 3", rises.size());
    end else begin
      vectors++;
      if (rises[1] - rises[0] != 300) begin
        miscompares++;
        $display("FAIL busy_skip_gap1: got %0d cycles, expected 300", rises[1] - rises[0]);
      end
      vectors++;
      if (rises[2] - rises[1] != 600) begin
        miscompares++;
        $display("FAIL busy_skip_gap2: got %0d cycles, expected 600", rises[2] - rises[1]);
      end
    end
    rst2 = 1'b1;
  endtask

  initial begin
    test_reset();
    run_frame(0, 0, 1'b0, "f1_first");
    run_frame(30, 0, 1'b0, "f2_h30");
    run_frame(30, 157, 1'b1, "f3_clip");
    run_frame(30, 157, 1'b0, "f4_obs_gone");
    run_frame(200, 60, 1'b1, "f5_clamp");
    test_reset_mid_frame();
    test_render_disabled();
    test_tick_during_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
